// File: rtl/inst_dispatch_queue.sv
// Decoded-instruction dispatch queue between the decoder and the issue stage.
// Buffers decoded instructions in a circular FIFO and presents the head
// combinationally as a single dispatch slot. A JALR blocks further issue until
// its target resolves; a mispredict flush discards every queued entry.
//
// Ports:
//   clk_in, rst_in (async, active-low)      clock / reset
//   rdy_in                                  global enable, 0 freezes all state
//   flush                                   mispredict, empties the queue
//   dec_valid, dec_*                        decoder push interface
//   full                                    queue holds DEPTH entries
//   op .. addr, inst_valid                  head dispatch slot
//   rs_launch_fail, lsb_launch_fail         consumer back-pressure
//   jalr_done                               JALR target resolved (pulse)

package inst_dispatch_queue_pkg;
  typedef struct packed {
    logic [4:0]  op;
    logic        branch;
    logic        ls;
    logic        use_imm;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic        jalr;
    logic [31:0] addr;
  } entry_t;
endpackage

module inst_dispatch_queue
  import inst_dispatch_queue_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned PTR_W = 3
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        flush,
  input  logic        dec_valid,
  input  logic [4:0]  dec_op,
  input  logic        dec_branch,
  input  logic        dec_ls,
  input  logic        dec_use_imm,
  input  logic [4:0]  dec_rd,
  input  logic [4:0]  dec_rs1,
  input  logic [4:0]  dec_rs2,
  input  logic [31:0] dec_imm,
  input  logic        dec_jalr,
  input  logic [31:0] dec_addr,
  output logic        full,
  output logic [4:0]  op,
  output logic        branch,
  output logic        ls,
  output logic        use_imm,
  output logic [4:0]  rd,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [31:0] imm,
  output logic        jalr,
  output logic [31:0] addr,
  output logic        inst_valid,
  input  logic        rs_launch_fail,
  input  logic        lsb_launch_fail,
  input  logic        jalr_done
);

  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic {
    ISSUE     = 1'b0,
    WAIT_JALR = 1'b1
  } state_t;

  state_t           state;
  state_t           state_nxt;
  entry_t           mem [DEPTH];
  entry_t           dec_entry;
  entry_t           head;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;
  logic             empty;
  logic             push;
  logic             pop;

  assign dec_entry = {dec_op, dec_branch, dec_ls, dec_use_imm, dec_rd, dec_rs1,
                      dec_rs2, dec_imm, dec_jalr, dec_addr};

  assign empty = (count == '0);
  assign full  = (count == CNT_W'(DEPTH));

  // Head slot: blanked while empty or while a JALR is outstanding.
  assign head       = (empty || state == WAIT_JALR) ? '0 : mem[rd_ptr];
  assign inst_valid = !empty && (state == ISSUE) && !flush;

  // Both moves are gated by rdy_in so a pause freezes everything.
  assign push = rdy_in && dec_valid && !full && !flush;
  assign pop  = rdy_in && inst_valid && !rs_launch_fail && !lsb_launch_fail;

  assign op      = head.op;
  assign branch  = head.branch;
  assign ls      = head.ls;
  assign use_imm = head.use_imm;
  assign rd      = head.rd;
  assign rs1     = head.rs1;
  assign rs2     = head.rs2;
  assign imm     = head.imm;
  assign jalr    = head.jalr;
  assign addr    = head.addr;

  // Entry storage; contents are only meaningful between rd_ptr and wr_ptr.
  always_ff @(posedge clk_in) begin
    if (push) begin
      mem[wr_ptr] <= dec_entry;
    end
  end

  // Pointers and occupancy.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (rdy_in) begin
      if (flush) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PTR_W'(1);
        if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
        case ({push, pop})
          2'b10:   count <= count + CNT_W'(1);
          2'b01:   count <= count - CNT_W'(1);
          default: count <= count;
        endcase
      end
    end
  end

  // Issue FSM state register.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state <= ISSUE;
    end else if (rdy_in) begin
      state <= state_nxt;
    end
  end

  // Issue FSM next state: a popped JALR stalls issue until jalr_done.
  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = ISSUE;
    end else begin
      case (state)
        ISSUE:     if (pop && head.jalr) state_nxt = WAIT_JALR;
        WAIT_JALR: if (jalr_done)        state_nxt = ISSUE;
        default:   state_nxt = ISSUE;
      endcase
    end
  end

endmodule
